// File: rtl/demux_pkg.sv
// Shared constants for the registered 1:2 bus router and its output slots.
package demux_pkg;

  localparam int   DEMUX_WIDTH_DEF = 32;
  localparam logic SEL_A           = 1'b0;
  localparam logic SEL_B           = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// One-entry registered output slot with valid/ready handshake.
// free means the slot can take a beat on the coming edge (empty, or draining now).
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      // A load while draining reloads in place: no bubble between beats.
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign free      = !r_valid || out_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule : demux_out_slot

// File: rtl/demux1to2_bus_reg.sv
// Registered 1:2 bus router: steers each input beat to slot A or B by in_sel.
// Optional BROADCAST_EN adds in_bcast, which loads both slots on the same edge.
module demux1to2_bus_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
`ifdef BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
);

  logic w_free_a;
  logic w_free_b;
  logic w_in_ready;
  logic w_load_a;
  logic w_load_b;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_in_ready = (in_sel == SEL_B) ? w_free_b : w_free_a;
    w_load_a   = in_valid && w_in_ready && (in_sel == SEL_A);
    w_load_b   = in_valid && w_in_ready && (in_sel == SEL_B);
`ifdef BROADCAST_EN
    if (in_bcast) begin
      w_in_ready = w_free_a && w_free_b;
      w_load_a   = in_valid && w_in_ready;
      w_load_b   = in_valid && w_in_ready;
    end
`endif
  end

  assign in_ready = w_in_ready;

  demux_out_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load_a),
    .load_data (in_data),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .free      (w_free_a)
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load_b),
    .load_data (in_data),
    .out_data  (b_data),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .free      (w_free_b)
  );

endmodule : demux1to2_bus_reg

// File: tb/tb_demux1to2_bus_reg.sv
// Directed and randomized checks for demux1to2_bus_reg (optionally with BROADCAST_EN).
module tb_demux1to2_bus_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_bcast;
  logic         in_ready;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];

  always #5 clk = ~clk;

  demux1to2_bus_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
`ifdef BROADCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         exp_ready;
    logic         acc;
    logic [W-1:0] got_q;

    reset    = 1'b1;
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    in_bcast = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_b_data", b_data, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: async reset while A is stalled with a beat.
    in_data  = 32'h5555_AAAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_a_loaded", a_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t1_async_a_valid", a_valid, 0);
    check("t1_async_a_data", a_data, 0);
    check("t1_async_b_valid", b_valid, 0);
    #1 reset = 1'b0;
    step();
    check("t1_no_ghost_beat", a_valid, 0);

    // Test 2: single beat to A.
    a_ready  = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    #1;
    check("t2_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t2_a_valid", a_valid, 1);
    check("t2_a_data", a_data, 32'hDEAD_BEEF);
    check("t2_b_valid", b_valid, 0);
    step();
    check("t2_a_drained", a_valid, 0);
    check("t2_a_data_held", a_data, 32'hDEAD_BEEF);

    // Test 3: eight back-to-back beats to B.
    b_ready = 1'b1;
    in_sel  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data  = W'(i);
      in_valid = 1'b1;
      #1;
      check($sformatf("t3_in_ready_%0d", i), in_ready, 1);
      step();
      check($sformatf("t3_b_valid_%0d", i), b_valid, 1);
      check($sformatf("t3_b_data_%0d", i), b_data, i);
    end
    in_valid = 1'b0;
    step();
    check("t3_b_idle", b_valid, 0);

    // Test 4: A stalls, B proceeds, then A drains and refills in one cycle.
    a_ready  = 1'b0;
    in_sel   = 1'b0;
    in_data  = 32'h0000_00A1;
    in_valid = 1'b1;
    step();
    in_data = 32'h0000_00A2;
    #1;
    check("t4_blocked", in_ready, 0);
    step();
    check("t4_a_hold_valid", a_valid, 1);
    check("t4_a_hold_data", a_data, 32'h0000_00A1);
    in_sel  = 1'b1;
    in_data = 32'h0000_00B1;
    #1;
    check("t4_b_ready_path", in_ready, 1);
    step();
    check("t4_b_valid", b_valid, 1);
    check("t4_b_data", b_data, 32'h0000_00B1);
    check("t4_a_still_held", a_data, 32'h0000_00A1);
    in_sel  = 1'b0;
    in_data = 32'h0000_00A2;
    a_ready = 1'b1;
    #1;
    check("t4_drain_fill_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_refill_valid", a_valid, 1);
    check("t4_refill_data", a_data, 32'h0000_00A2);
    step();
    check("t4_a_done", a_valid, 0);
    check("t4_b_done", b_valid, 0);

`ifdef BROADCAST_EN
    // Test 5: broadcast waits for both slots, then loads both on one edge.
    b_ready  = 1'b0;
    in_sel   = 1'b1;
    in_data  = 32'h0000_00BB;
    in_valid = 1'b1;
    step();
    in_bcast = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'h1234_5678;
    #1;
    check("t5_bcast_blocked", in_ready, 0);
    step();
    check("t5_a_not_loaded", a_valid, 0);
    b_ready = 1'b1;
    #1;
    check("t5_bcast_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    check("t5_a_valid", a_valid, 1);
    check("t5_b_valid", b_valid, 1);
    check("t5_a_data", a_data, 32'h1234_5678);
    check("t5_b_data", b_data, 32'h1234_5678);
    step();
`endif

    // Test 6: random traffic against per-output scoreboard queues.
    q_a.delete();
    q_b.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      a_ready  = ($urandom_range(0, 9) < 6);
      b_ready  = ($urandom_range(0, 9) < 6);
`ifdef BROADCAST_EN
      in_bcast = ($urandom_range(0, 7) == 0);
`endif
      #1;
      check("r_a_valid", a_valid, q_a.size() != 0);
      check("r_b_valid", b_valid, q_b.size() != 0);
      if (in_bcast)
        exp_ready = (q_a.size() == 0 || a_ready) && (q_b.size() == 0 || b_ready);
      else if (in_sel)
        exp_ready = (q_b.size() == 0 || b_ready);
      else
        exp_ready = (q_a.size() == 0 || a_ready);
      check("r_in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;
      if (a_valid && a_ready) begin
        if (q_a.size() == 0) check("r_a_extra_beat", 1, 0);
        else begin
          got_q = q_a.pop_front();
          check("r_a_data", a_data, got_q);
        end
      end
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) check("r_b_extra_beat", 1, 0);
        else begin
          got_q = q_b.pop_front();
          check("r_b_data", b_data, got_q);
        end
      end
      if (acc && (in_bcast || !in_sel)) q_a.push_back(in_data);
      if (acc && (in_bcast || in_sel))  q_b.push_back(in_data);
      step();
    end

    // Drain whatever is left and confirm nothing was lost.
    in_valid = 1'b0;
    in_bcast = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    #1;
    if (a_valid) begin
      got_q = (q_a.size() != 0) ? q_a.pop_front() : ~a_data;
      check("drain_a_data", a_data, got_q);
    end
    if (b_valid) begin
      got_q = (q_b.size() != 0) ? q_b.pop_front() : ~b_data;
      check("drain_b_data", b_data, got_q);
    end
    check("drain_q_a_empty", q_a.size(), 0);
    check("drain_q_b_empty", q_b.size(), 0);
    step();
    check("drain_a_idle", a_valid, 0);
    check("drain_b_idle", b_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_demux1to2_bus_reg
